steer_cmd_gen: RTL and testbench
================================

Name: steer_cmd_gen

Overview:
- Upstream stage of the servo PWM steering block.
- Converts the stream of signed lag estimates from the microphone cross-correlation engine into the 2-bit `direct` command consumed by the servo stage: 00 hold, 01 decrement pulse width, 10 increment pulse width, 11 recentre.
- Applies confidence gating, a deadband and N-consecutive debounce.
- Holds each command long enough to be sampled by the servo stage's slow update edge, and recentres the servo after prolonged silence.

Parameters:
- LAG_W, 8, width of signed lag input (two's complement samples).
- PEAK_W, 16, width of unsigned correlation peak magnitude.
- PEAK_MIN, 1024, minimum peak for an estimate to be accepted.
- DEADBAND, 2, |lag| <= DEADBAND classifies as centred.
- CONFIRM_N, 3, consecutive same-class accepted estimates required to issue a command (>=1).
- HOLD_CYC, 1080000, clocks a command stays on `direct` (one servo update period at 27 MHz).
- TIMEOUT_CYC, 135000000, clocks without an accepted estimate before auto-recentre (5 s).

Ports:
- clk  in  1  27 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- lag_valid  in  1  single-cycle strobe, lag/peak valid.
- lag  in  LAG_W  signed lag estimate.
- peak  in  PEAK_W  correlation peak magnitude for this estimate.
- center_req  in  1  single-cycle manual recentre request.
- direct  out  2  command to servo stage; registered.
- cmd_active  out  1  high while a non-00 command is being held.
- timeout_pulse  out  1  one-cycle pulse when the silence timeout fires.

Behaviour:
- Reset (async, rst_n=0):
  - direct=00, cmd_active=0, timeout_pulse=0.
  - State IDLE; debounce count=0; last class=ZERO.
  - Hold and timeout counters cleared; timeout armed.
- Accept: lag_valid=1 and peak >= PEAK_MIN. Estimates with peak < PEAK_MIN are ignored entirely (no class, no debounce or timeout effect).
- Classify (signed compare, lag sign-extended against DEADBAND):
  - lag > +DEADBAND -> INC (10).
  - lag < -DEADBAND -> DEC (01).
  - otherwise ZERO.
- Debounce:
  - Accepted class equal to last class -> count = count+1, saturating at CONFIRM_N.
  - Different class -> count=1, last class updated.
  - Confirm fires on the accepted cycle where count reaches CONFIRM_N, and on every further same-class accepted estimate.
- States:
  - IDLE: direct=00.
    - Confirm of INC/DEC -> DRIVE, load hold counter with HOLD_CYC.
    - Confirm of ZERO -> stays IDLE.
  - DRIVE: direct = confirmed class.
    - Hold counter decrements each clock.
    - Same-class confirm reloads HOLD_CYC (retrigger).
    - Opposite-class confirm switches direct immediately and reloads.
    - ZERO confirm -> IDLE next cycle.
    - Counter reaching 0 -> IDLE, direct=00.
  - CENTER: direct=11 for HOLD_CYC clocks, then IDLE.
    - Accepted estimates update debounce but cannot leave CENTER early.
- Latency: `direct` updates on the clock edge after the confirming lag_valid (1 cycle).
- Silence timeout:
  - Counter clears on every accepted estimate; otherwise increments.
  - At TIMEOUT_CYC: one-cycle timeout_pulse, enter CENTER, clear debounce, disarm.
  - Re-arms only on the next accepted estimate, so there is exactly one recentre per silence.
- center_req: enter CENTER from any state next cycle; clears debounce and timeout counter.
  - center_req wins over lag_valid in the same cycle; that estimate is discarded.
  - center_req during CENTER reloads HOLD_CYC.
- cmd_active = (direct != 00), registered together with direct.
- Width rules:
  - Hold and timeout counters are $clog2(param+1) wide.
  - Timeout counter saturates and never wraps.
  - Debounce count is $clog2(CONFIRM_N+1) wide.
- Reset mid-hold: direct drops to 00 asynchronously.

Decomposition:
- Package steer_pkg:
  - Direct-code constants DIR_HOLD=2'b00, DIR_DEC=2'b01, DIR_INC=2'b10, DIR_CENTER=2'b11.
  - State enum IDLE/DRIVE/CENTER.
  - Class enum ZERO/DEC/INC.
- One sub-module, steer_hold_timer: loadable down-counter with load/value inputs and an `expired` output. Instanced once for the hold counter; the timeout counter stays inline.

Test Plan:
(Bench parameters: CONFIRM_N=3, HOLD_CYC=20, TIMEOUT_CYC=100, DEADBAND=2, PEAK_MIN=16.)
1. Three accepted estimates lag=+5, peak=100, 4 clocks apart -> direct=10 one clock after the 3rd strobe; held 20 clocks, then 00. cmd_active tracks direct.
2. Sequence lag +5, +5, -5, -5, -5 (peak 100) -> no command until the 5th strobe, then direct=01. lag=+2 three times -> direct stays 00 (deadband).
3. Three lag=+5 with peak=15 -> ignored, direct=00. After 100 idle clocks with no accepted estimate -> timeout_pulse for 1 cycle, direct=11 for 20 clocks, then 00, and no second timeout while silent.
4. In DRIVE(10), a 4th lag=+5 at hold count 3 -> hold reloads to 20. Three lag=0 -> direct=00 next cycle after the 3rd.
5. center_req and an accepted lag_valid in the same cycle during DRIVE -> direct=11 next cycle, lag discarded, debounce cleared (two further +5 estimates must not confirm).
6. rst_n asserted mid-DRIVE -> direct=00 and cmd_active=0 immediately. After release, a fresh 3-estimate confirm is required.

Source files
------------

// File: rtl/steer_pkg.sv
// steer_pkg: shared definitions for the steering command generator.
//   - direct-code constants driven to the servo stage
//   - FSM state enum and lag-class enum
//   - helper converting a lag class into its direct code
package steer_pkg;

  localparam logic [1:0] DIR_HOLD   = 2'b00;
  localparam logic [1:0] DIR_DEC    = 2'b01;
  localparam logic [1:0] DIR_INC    = 2'b10;
  localparam logic [1:0] DIR_CENTER = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    CENTER = 2'b10
  } state_t;

  // Class encodings match the direct codes they produce.
  typedef enum logic [1:0] {
    ZERO = 2'b00,
    DEC  = 2'b01,
    INC  = 2'b10
  } cls_t;

  function automatic logic [1:0] cls_to_dir(input cls_t c);
    return 2'(c);
  endfunction

endpackage

// File: rtl/steer_hold_timer.sv
// steer_hold_timer: loadable down-counter that stops at zero.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load `value` this clock (takes priority over counting)
//   value      : reload value
//   expired    : high while the count is zero
module steer_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/steer_cmd_gen.sv
// steer_cmd_gen: turns cross-correlation lag estimates into servo commands.
//   clk, rst_n     : clock, asynchronous active-low reset
//   lag_valid      : single-cycle strobe qualifying lag/peak
//   lag            : signed lag estimate
//   peak           : correlation peak magnitude (confidence)
//   center_req     : single-cycle manual recentre request
//   direct         : registered command 00 hold, 01 dec, 10 inc, 11 recentre
//   cmd_active     : registered, high while direct != 00
//   timeout_pulse  : one-cycle pulse when the silence timeout fires
//
// state  | meaning
// IDLE   | no command, direct = 00
// DRIVE  | holding an INC/DEC command until hold timer expires
// CENTER | holding recentre (11) for one hold period
module steer_cmd_gen
  import steer_pkg::*;
#(
  parameter int LAG_W       = 8,
  parameter int PEAK_W      = 16,
  parameter int PEAK_MIN    = 1024,
  parameter int DEADBAND    = 2,
  parameter int CONFIRM_N   = 3,
  parameter int HOLD_CYC    = 1080000,
  parameter int TIMEOUT_CYC = 135000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lag_valid,
  input  logic [LAG_W-1:0]  lag,
  input  logic [PEAK_W-1:0] peak,
  input  logic              center_req,
  output logic [1:0]        direct,
  output logic              cmd_active,
  output logic              timeout_pulse
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W  = $clog2(CONFIRM_N + 1);

  // The timer holds the command while counting down to zero inclusive,
  // so loading HOLD_CYC-1 keeps direct up for exactly HOLD_CYC clocks.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CONFIRM_N);
  localparam logic [PEAK_W-1:0] PEAK_THR  = PEAK_W'(PEAK_MIN);

  state_t           state, state_next;
  cls_t             last_cls, cls;
  logic [CNT_W-1:0] db_cnt, db_cnt_upd;
  logic [TMO_W-1:0] tmo_cnt;
  logic             armed;
  logic             accept, confirm, tmo_fire;
  logic             hold_load, hold_expired;
  logic [1:0]       dir_next;
  logic signed [31:0] lag_ext;

  // A manual recentre in the same cycle discards the estimate.
  assign accept = lag_valid && (peak >= PEAK_THR) && !center_req;

  assign lag_ext = {{(32 - LAG_W){lag[LAG_W-1]}}, lag};

  always_comb begin
    cls = ZERO;
    if (lag_ext > DEADBAND) begin
      cls = INC;
    end else if (lag_ext < -DEADBAND) begin
      cls = DEC;
    end
  end

  // Debounce: run length of identical accepted classes, saturating.
  always_comb begin
    db_cnt_upd = CNT_W'(1);
    if (cls == last_cls) begin
      db_cnt_upd = (db_cnt == CNT_MAX) ? CNT_MAX : db_cnt + CNT_W'(1);
    end
  end

  assign confirm = accept && (db_cnt_upd == CNT_MAX);

  // Fires on the clock where the silence count reaches TIMEOUT_CYC.
  assign tmo_fire = armed && !accept && !center_req && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      last_cls <= ZERO;
    end else if (center_req || tmo_fire) begin
      db_cnt   <= '0;
      last_cls <= ZERO;
    end else if (accept) begin
      db_cnt   <= db_cnt_upd;
      last_cls <= cls;
    end
  end

  // Saturates at TIMEOUT_CYC; disarms after firing so a long silence
  // produces a single recentre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      armed   <= 1'b1;
    end else if (accept) begin
      tmo_cnt <= '0;
      armed   <= 1'b1;
    end else if (center_req) begin
      tmo_cnt <= '0;
    end else if (tmo_fire) begin
      tmo_cnt <= TMO_MAX;
      armed   <= 1'b0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  steer_hold_timer #(
    .W(HOLD_W)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .value   (HOLD_LOAD),
    .expired (hold_expired)
  );

  always_comb begin
    state_next = state;
    dir_next   = direct;
    hold_load  = 1'b0;
    if (center_req || tmo_fire) begin
      state_next = CENTER;
      dir_next   = DIR_CENTER;
      hold_load  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          dir_next = DIR_HOLD;
          if (confirm && cls != ZERO) begin
            state_next = DRIVE;
            dir_next   = cls_to_dir(cls);
            hold_load  = 1'b1;
          end
        end
        DRIVE: begin
          if (confirm) begin
            if (cls == ZERO) begin
              state_next = IDLE;
              dir_next   = DIR_HOLD;
            end else begin
              dir_next  = cls_to_dir(cls);
              hold_load = 1'b1;
            end
          end else if (hold_expired) begin
            state_next = IDLE;
            dir_next   = DIR_HOLD;
          end
        end
        CENTER: begin
          if (hold_expired) begin
            state_next = IDLE;
            dir_next   = DIR_HOLD;
          end
        end
        default: begin
          state_next = IDLE;
          dir_next   = DIR_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      direct        <= DIR_HOLD;
      cmd_active    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      direct        <= dir_next;
      cmd_active    <= (dir_next != DIR_HOLD);
      timeout_pulse <= tmo_fire;
    end
  end

endmodule

// File: tb/tb_steer_cmd_gen.sv
// tb_steer_cmd_gen: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the steering rules.
module tb_steer_cmd_gen;

  localparam int P_HOLD = 20;
  localparam int P_TMO  = 100;
  localparam int P_N    = 3;
  localparam int P_DB   = 2;
  localparam int P_PMIN = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lag_valid = 1'b0;
  logic signed [7:0] lag_s = '0;
  logic [15:0]       peak = '0;
  logic              center_req = 1'b0;
  logic [1:0]        direct;
  logic              cmd_active;
  logic              timeout_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model: expected direct, remaining hold clocks, debounce run, silence
  int m_dir, m_hold, m_run_cls, m_run_len, m_quiet, m_armed, m_fire;

  steer_cmd_gen #(
    .LAG_W(8), .PEAK_W(16), .PEAK_MIN(P_PMIN), .DEADBAND(P_DB),
    .CONFIRM_N(P_N), .HOLD_CYC(P_HOLD), .TIMEOUT_CYC(P_TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lag_valid     (lag_valid),
    .lag           (lag_s),
    .peak          (peak),
    .center_req    (center_req),
    .direct        (direct),
    .cmd_active    (cmd_active),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_hold = 0; m_run_cls = 0; m_run_len = 0;
    m_quiet = 0; m_armed = 1; m_fire = 0;
  endtask

  // One clock of the steering rules: 0 zero, 1 dec, 2 inc, 3 centre.
  task automatic model_step(input int v, input int l, input int p, input int c);
    int cls;
    bit acc, confirmed;
    acc = (v != 0) && (p >= P_PMIN) && (c == 0);
    cls = (l > P_DB) ? 2 : ((l < -P_DB) ? 1 : 0);
    confirmed = 0;
    m_fire = 0;
    if (c != 0) begin
      m_run_len = 0; m_run_cls = 0; m_quiet = 0;
      m_dir = 3; m_hold = P_HOLD;
      return;
    end
    if (acc) begin
      m_quiet = 0;
      m_armed = 1;
      if (cls == m_run_cls) m_run_len = (m_run_len < P_N) ? m_run_len + 1 : P_N;
      else begin
        m_run_len = 1; m_run_cls = cls;
      end
      confirmed = (m_run_len == P_N);
    end else if (m_quiet < P_TMO) begin
      m_quiet++;
      if (m_quiet == P_TMO && m_armed == 1) begin
        m_fire = 1; m_armed = 0;
        m_run_len = 0; m_run_cls = 0;
        m_dir = 3; m_hold = P_HOLD;
        return;
      end
    end
    if (confirmed && m_dir != 3) begin
      if (cls == 0) m_dir = 0;
      else begin
        m_dir = cls; m_hold = P_HOLD;
      end
    end else if (m_dir != 0) begin
      m_hold--;
      if (m_hold == 0) m_dir = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input int v, input int l, input int p, input int c);
    lag_valid  = (v != 0);
    lag_s      = 8'(l);
    peak       = 16'(p);
    center_req = (c != 0);
    @(posedge clk);
    model_step(v, l, p, c);
    #1;
    chk("direct", 32'(direct), m_dir);
    chk("cmd_active", 32'(cmd_active), (m_dir != 0) ? 1 : 0);
    chk("timeout_pulse", 32'(timeout_pulse), m_fire);
    @(negedge clk);
    lag_valid = 1'b0; center_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic est(input int l, input int gap);
    tick(1, l, 100, 0);
    idle(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lag_valid = 1'b0; center_req = 1'b0; lag_s = '0; peak = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_direct", 32'(direct), 0);
    chk("rst_cmd_active", 32'(cmd_active), 0);
    chk("rst_timeout_pulse", 32'(timeout_pulse), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses, centre_cyc;
    model_reset();

    // 1: three +5 confirm INC, held for P_HOLD clocks
    do_reset();
    est(5, 3); est(5, 3);
    tick(1, 5, 100, 0);
    chk("t1_inc", 32'(direct), 2);
    idle(P_HOLD - 1);
    chk("t1_still_inc", 32'(direct), 2);
    idle(1);
    chk("t1_released", 32'(direct), 0);

    // 2: class change restarts debounce; deadband gives no command
    do_reset();
    est(5, 3); est(5, 3); est(-5, 3); est(-5, 3);
    chk("t2_no_cmd_yet", 32'(direct), 0);
    tick(1, -5, 100, 0);
    chk("t2_dec", 32'(direct), 1);
    do_reset();
    est(2, 3); est(2, 3); est(2, 3);
    chk("t2_deadband", 32'(direct), 0);

    // 3: low-peak estimates ignored; single timeout recentre
    do_reset();
    tick(1, 5, 15, 0); tick(1, 5, 15, 0); tick(1, 5, 15, 0);
    chk("t3_low_peak", 32'(direct), 0);
    pulses = 0; centre_cyc = 0;
    for (int i = 0; i < 150; i++) begin
      tick(0, 0, 0, 0);
      if (timeout_pulse) pulses++;
      if (direct == 2'b11) centre_cyc++;
    end
    chk("t3_one_pulse", pulses, 1);
    chk("t3_centre_len", centre_cyc, P_HOLD);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick(0, 0, 0, 0);
      if (timeout_pulse) pulses++;
    end
    chk("t3_no_second", pulses, 0);

    // 4: retrigger at hold count 3, then ZERO confirm ends DRIVE
    do_reset();
    est(5, 3); est(5, 3); est(5, 0);
    idle(P_HOLD - 3);
    tick(1, 5, 100, 0);
    idle(10);
    chk("t4_reloaded", 32'(direct), 2);
    tick(1, 0, 100, 0); tick(1, 0, 100, 0);
    chk("t4_before_zero", 32'(direct), 2);
    tick(1, 0, 100, 0);
    chk("t4_zero_idle", 32'(direct), 0);

    // 5: center_req beats a same-cycle estimate and clears debounce
    do_reset();
    est(5, 3); est(5, 3); est(5, 2);
    tick(1, 5, 100, 1);
    chk("t5_centre", 32'(direct), 3);
    est(5, 3); est(5, 3);
    idle(20);
    chk("t5_no_confirm", 32'(direct), 0);

    // 6: async reset mid-DRIVE; fresh confirm needed afterwards
    do_reset();
    est(5, 3); est(5, 3); est(5, 5);
    chk("t6_driving", 32'(direct), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_dir", 32'(direct), 0);
    chk("t6_async_act", 32'(cmd_active), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    est(5, 1);
    chk("t6_one_est", 32'(direct), 0);
    est(5, 1);
    tick(1, 5, 100, 0);
    chk("t6_reconfirm", 32'(direct), 2);

    // randomized traffic against the model, with silences for timeouts
    do_reset();
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 40; i++) begin
        tick(($urandom % 3) == 0, int'($urandom_range(0, 12)) - 6,
             int'($urandom_range(0, 40)), ($urandom % 97) == 0);
      end
      idle(int'($urandom_range(0, 130)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
